// File: rtl/pci_bridge_wb_arbiter_if.sv
// WISHBONE bundle between the NUM_M system masters, the round-robin arbiter
// and the PCI bridge slave port.
//   master : the requesting masters' view (drive m_*, receive responses)
//   slave  : the arbiter's view (slave to the masters, drives the bridge)
//   bridge : the PCI bridge slave port's view
interface pci_bridge_wb_arbiter_if #(
  parameter int NUM_M = 4
);

  // Master-side request group, master i occupies slice i of each vector
  logic [NUM_M-1:0]    m_cyc;
  logic [NUM_M-1:0]    m_stb;
  logic [NUM_M-1:0]    m_we;
  logic [NUM_M-1:0]    m_cab;
  logic [NUM_M*32-1:0] m_adr;
  logic [NUM_M*32-1:0] m_dat;
  logic [NUM_M*4-1:0]  m_sel;
  logic [NUM_M*3-1:0]  m_cti;
  logic [NUM_M*2-1:0]  m_bte;

  // Master-side response group
  logic [31:0]         m_dat_o;
  logic [NUM_M-1:0]    m_ack;
  logic [NUM_M-1:0]    m_rty;
  logic [NUM_M-1:0]    m_err;

  // Bridge slave inputs
  logic [31:0]         ADR_I;
  logic [31:0]         SDAT_I;
  logic [3:0]          SEL_I;
  logic                CYC_I;
  logic                STB_I;
  logic                WE_I;
  logic                CAB_I;
  logic [2:0]          CTI_I;
  logic [1:0]          BTE_I;

  // Bridge slave outputs
  logic [31:0]         SDAT_O;
  logic                ACK_O;
  logic                RTY_O;
  logic                ERR_O;

  modport master (
    output m_cyc, m_stb, m_we, m_cab, m_adr, m_dat, m_sel, m_cti, m_bte,
    input  m_dat_o, m_ack, m_rty, m_err
  );

  modport slave (
    input  m_cyc, m_stb, m_we, m_cab, m_adr, m_dat, m_sel, m_cti, m_bte,
    output m_dat_o, m_ack, m_rty, m_err,
    output ADR_I, SDAT_I, SEL_I, CYC_I, STB_I, WE_I, CAB_I, CTI_I, BTE_I,
    input  SDAT_O, ACK_O, RTY_O, ERR_O
  );

  modport bridge (
    input  ADR_I, SDAT_I, SEL_I, CYC_I, STB_I, WE_I, CAB_I, CTI_I, BTE_I,
    output SDAT_O, ACK_O, RTY_O, ERR_O
  );

endinterface

// File: rtl/pci_bridge_wb_arbiter.sv
// Round-robin arbiter sharing the PCI bridge WISHBONE slave port among
// NUM_M masters. One grant is registered per WISHBONE cycle and held until
// the owner drops CYC; the owner's request group is muxed onto the bridge
// inputs and the bridge responses are steered back to the owner only.
// Every release is followed by one turnaround cycle with CYC_I low.
//
// Optional build macro PCI_BRIDGE_WB_ARB_WATCHDOG_EN adds a 10-bit
// no-response watchdog that errors out a hung cycle after 1023 strobed
// cycles without ACK/RTY/ERR. Without it a hung slave keeps the grant.
module pci_bridge_wb_arbiter #(
  parameter int NUM_M = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pci_bridge_wb_arbiter_if.slave bus,
  output logic [NUM_M-1:0]      gnt,
  output logic                  busy
);

  localparam int GNT_W = $clog2(NUM_M);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [GNT_W-1:0]   gnt_idx;
  logic [GNT_W-1:0]   gnt_idx_nxt;
  logic [GNT_W-1:0]   last;
  logic [GNT_W-1:0]   last_nxt;
  logic [NUM_M-1:0]   gnt_nxt;

  logic               pick_valid;
  logic [GNT_W-1:0]   pick_idx;
  logic               owner_cyc;
  logic               owner_stb;
  logic               any_rsp;

  // Watchdog hooks; tied off when the watchdog is not built
  logic               wd_fire;
  logic               wd_block;

  assign owner_cyc = |(gnt & bus.m_cyc);
  assign owner_stb = |(gnt & bus.m_stb);
  assign any_rsp   = bus.ACK_O | bus.RTY_O | bus.ERR_O;
  assign busy      = (state == OWNED);

  // Round-robin search: first requester after the last owner, wrapping
  always_comb begin
    int               cand;
    logic [GNT_W-1:0] cand_idx;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int off = 1; off <= NUM_M; off++) begin
      cand     = (int'(last) + off) % NUM_M;
      cand_idx = GNT_W'(cand);
      if (!pick_valid && bus.m_cyc[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Next-state, next-grant and round-robin pointer update
  always_comb begin
    state_nxt   = state;
    gnt_idx_nxt = gnt_idx;
    last_nxt    = last;
    gnt_nxt     = '0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt   = OWNED;
          gnt_idx_nxt = pick_idx;
        end
      end
      OWNED: begin
        if (!owner_cyc) begin
          state_nxt = GAP;
          last_nxt  = gnt_idx;
        end
      end
      GAP: begin
        // The turnaround cycle also arbitrates on its way out, so a pending
        // master is granted right after exactly one idle bus cycle.
        if (pick_valid) begin
          state_nxt   = OWNED;
          gnt_idx_nxt = pick_idx;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (state_nxt == OWNED) begin
      gnt_nxt[gnt_idx_nxt] = 1'b1;
    end
  end

  // State, grant and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      last    <= GNT_W'(NUM_M - 1);
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      gnt_idx <= gnt_idx_nxt;
      last    <= last_nxt;
    end
  end

`ifdef PCI_BRIDGE_WB_ARB_WATCHDOG_EN
  logic [9:0] wd_cnt;
  logic       wd_kill;

  assign wd_fire  = (state == OWNED) && !wd_kill && !any_rsp &&
                    (wd_cnt == 10'd1023);
  assign wd_block = wd_kill | wd_fire;

  // No-response counter; restarts on every grant and every bridge response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      wd_kill <= 1'b0;
    end else if (state != OWNED) begin
      wd_cnt  <= '0;
      wd_kill <= 1'b0;
    end else begin
      if (wd_fire) begin
        wd_kill <= 1'b1;
      end
      if (any_rsp) begin
        wd_cnt <= '0;
      end else if (bus.STB_I && (wd_cnt != 10'd1023)) begin
        wd_cnt <= wd_cnt + 10'd1;
      end
    end
  end
`else
  assign wd_fire  = 1'b0;
  assign wd_block = 1'b0;
`endif

  // Mux the owner's request group onto the bridge; all zero without a grant
  always_comb begin
    bus.ADR_I  = '0;
    bus.SDAT_I = '0;
    bus.SEL_I  = '0;
    bus.CTI_I  = '0;
    bus.BTE_I  = '0;
    bus.WE_I   = 1'b0;
    bus.CAB_I  = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (gnt[i]) begin
        bus.ADR_I  = bus.m_adr[i*32 +: 32];
        bus.SDAT_I = bus.m_dat[i*32 +: 32];
        bus.SEL_I  = bus.m_sel[i*4 +: 4];
        bus.CTI_I  = bus.m_cti[i*3 +: 3];
        bus.BTE_I  = bus.m_bte[i*2 +: 2];
        bus.WE_I   = bus.m_we[i];
        bus.CAB_I  = bus.m_cab[i];
      end
    end
    bus.CYC_I = owner_cyc & ~wd_block;
    bus.STB_I = owner_stb & ~wd_block;
  end

  // Responses reach the owner only; with no grant they are dropped
  assign bus.m_ack   = gnt & {NUM_M{bus.ACK_O}};
  assign bus.m_rty   = gnt & {NUM_M{bus.RTY_O}};
  assign bus.m_err   = gnt & {NUM_M{bus.ERR_O | wd_fire}};
  assign bus.m_dat_o = bus.SDAT_O;

endmodule

// File: tb/tb_pci_bridge_wb_arbiter.sv
// Self-checking bench for pci_bridge_wb_arbiter (NUM_M = 4).
// Expected bridge-side beats are queued in expected service order when each
// test drives its masters; the bridge model pops and compares one entry per
// response it issues. Masters check their own response routing and read data.
// Honours PCI_BRIDGE_WB_ARB_WATCHDOG_EN for the hung-slave test.
module tb_pci_bridge_wb_arbiter;

  localparam int NUM_M = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [NUM_M-1:0] gnt;
  logic busy;

  always #5 clk = ~clk;

  pci_bridge_wb_arbiter_if #(.NUM_M(NUM_M)) bus ();

  pci_bridge_wb_arbiter #(.NUM_M(NUM_M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .gnt   (gnt),
    .busy  (busy)
  );

  // Per-master drive state
  logic        cyc_r [NUM_M];
  logic        stb_r [NUM_M];
  logic        we_r  [NUM_M];
  logic        cab_r [NUM_M];
  logic [31:0] adr_r [NUM_M];
  logic [31:0] dat_r [NUM_M];
  logic [3:0]  sel_r [NUM_M];
  logic [2:0]  cti_r [NUM_M];
  logic [1:0]  bte_r [NUM_M];

  // Bridge model and fault-injection drive
  logic        br_ack;
  logic        br_rty;
  logic [31:0] br_dat;
  logic        spur_ack;
  logic        spur_rty;
  logic        spur_err;
  logic        bridge_en;
  int          resp_delay;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    int          idx;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        we;
    logic [2:0]  cti;
    logic        rty;
    logic [31:0] rdata;
  } beat_t;

  beat_t exp_q[$];

  // Pack per-master drive state onto the interface
  always_comb begin
    bus.m_cyc = '0;
    bus.m_stb = '0;
    bus.m_we  = '0;
    bus.m_cab = '0;
    bus.m_adr = '0;
    bus.m_dat = '0;
    bus.m_sel = '0;
    bus.m_cti = '0;
    bus.m_bte = '0;
    for (int i = 0; i < NUM_M; i++) begin
      bus.m_cyc[i]          = cyc_r[i];
      bus.m_stb[i]          = stb_r[i];
      bus.m_we[i]           = we_r[i];
      bus.m_cab[i]          = cab_r[i];
      bus.m_adr[i*32 +: 32] = adr_r[i];
      bus.m_dat[i*32 +: 32] = dat_r[i];
      bus.m_sel[i*4 +: 4]   = sel_r[i];
      bus.m_cti[i*3 +: 3]   = cti_r[i];
      bus.m_bte[i*2 +: 2]   = bte_r[i];
    end
  end

  assign bus.ACK_O  = br_ack | spur_ack;
  assign bus.RTY_O  = br_rty | spur_rty;
  assign bus.ERR_O  = spur_err;
  assign bus.SDAT_O = br_dat;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] rd_pattern(input int idx, input int beat);
    return {16'hA5C3, 8'(idx), 8'(beat)};
  endfunction

  function automatic logic [2:0] cti_for(input int beats, input int b);
    if (beats == 1) return 3'b000;
    if (b == beats - 1) return 3'b111;
    return 3'b010;
  endfunction

  function automatic logic [NUM_M-1:0] onehot(input int idx);
    logic [NUM_M-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Queue the bridge-side beats a transaction is expected to produce
  task automatic push_txn(input int idx, input logic [31:0] adr,
                          input logic [31:0] wdat, input logic we,
                          input int beats, input logic rty);
    beat_t e;
    for (int b = 0; b < beats; b++) begin
      e.idx   = idx;
      e.adr   = adr + 32'(4 * b);
      e.wdat  = wdat + 32'(b);
      e.we    = we;
      e.cti   = cti_for(beats, b);
      e.rty   = rty;
      e.rdata = rd_pattern(idx, b);
      exp_q.push_back(e);
    end
  endtask

  // One master transaction: drive each beat, wait for its response, check routing
  task automatic applyStimulus(input int idx, input logic [31:0] adr,
                               input logic [31:0] wdat, input logic we,
                               input int beats, input logic rty);
    for (int b = 0; b < beats; b++) begin
      int   waited;
      logic got;
      waited     = 0;
      got        = 1'b0;
      adr_r[idx] = adr + 32'(4 * b);
      dat_r[idx] = wdat + 32'(b);
      we_r[idx]  = we;
      sel_r[idx] = 4'hF;
      cti_r[idx] = cti_for(beats, b);
      bte_r[idx] = 2'b00;
      cab_r[idx] = (beats > 1);
      cyc_r[idx] = 1'b1;
      stb_r[idx] = 1'b1;
      while (!got && waited < 300) begin
        @(negedge clk);
        waited++;
        if (bus.m_ack[idx] || bus.m_rty[idx] || bus.m_err[idx]) got = 1'b1;
      end
      if (!got) begin
        checkOutput($sformatf("timeout_m%0d", idx), 64'(0), 64'(1));
        break;
      end
      checkOutput($sformatf("m%0d_ack", idx), 64'(bus.m_ack),
                  rty ? 64'(0) : 64'(onehot(idx)));
      checkOutput($sformatf("m%0d_rty", idx), 64'(bus.m_rty),
                  rty ? 64'(onehot(idx)) : 64'(0));
      if (!we) checkOutput($sformatf("m%0d_rdat", idx), 64'(bus.m_dat_o),
                           64'(rd_pattern(idx, b)));
    end
    cyc_r[idx] = 1'b0;
    stb_r[idx] = 1'b0;
    cab_r[idx] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    checkOutput("sb_leftover", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      cyc_r[i] = 1'b0; stb_r[i] = 1'b0; we_r[i] = 1'b0; cab_r[i] = 1'b0;
      adr_r[i] = '0;   dat_r[i] = '0;   sel_r[i] = '0; cti_r[i] = '0;
      bte_r[i] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Bridge model: respond after resp_delay strobed cycles, check the beat
  initial begin
    int    wait_cnt;
    beat_t e;
    br_ack   = 1'b0;
    br_rty   = 1'b0;
    br_dat   = '0;
    wait_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      br_ack = 1'b0;
      br_rty = 1'b0;
      if (!bridge_en || !rst_n) begin
        wait_cnt = 0;
      end else if (bus.CYC_I && bus.STB_I) begin
        if (wait_cnt >= resp_delay) begin
          wait_cnt = 0;
          if (exp_q.size() == 0) begin
            checkOutput("sb_unexpected_beat", 64'(1), 64'(0));
            br_ack = 1'b1;
          end else begin
            e = exp_q.pop_front();
            checkOutput("sb_gnt",  64'(gnt),       64'(onehot(e.idx)));
            checkOutput("sb_adr",  64'(bus.ADR_I), 64'(e.adr));
            checkOutput("sb_we",   64'(bus.WE_I),  64'(e.we));
            checkOutput("sb_sel",  64'(bus.SEL_I), 64'(4'hF));
            checkOutput("sb_cti",  64'(bus.CTI_I), 64'(e.cti));
            if (e.we) checkOutput("sb_sdat", 64'(bus.SDAT_I), 64'(e.wdat));
            br_dat = e.rdata;
            if (e.rty) br_rty = 1'b1;
            else       br_ack = 1'b1;
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Turnaround monitor: each idle stretch between two CYC_I runs is one cycle
  logic gap_check_en = 1'b0;
  initial begin
    int   gap_run;
    logic seen_high;
    gap_run   = 0;
    seen_high = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!gap_check_en) begin
        gap_run   = 0;
        seen_high = 1'b0;
      end else if (bus.CYC_I) begin
        if (seen_high && gap_run > 0) checkOutput("rr_gap_cycles", 64'(gap_run), 64'(1));
        seen_high = 1'b1;
        gap_run   = 0;
      end else begin
        gap_run++;
      end
    end
  end

  // Hard stop in case some wait is never satisfied
  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  // Main test sequence
  initial begin
    spur_ack   = 1'b0;
    spur_rty   = 1'b0;
    spur_err   = 1'b0;
    bridge_en  = 1'b1;
    resp_delay = 1;
    rst_n      = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      cyc_r[i] = 1'b1; stb_r[i] = 1'b0; we_r[i] = 1'b0; cab_r[i] = 1'b0;
      adr_r[i] = 32'h0000_1000 * 32'(i + 1); dat_r[i] = '0;
      sel_r[i] = 4'hF; cti_r[i] = '0; bte_r[i] = '0;
    end

    // Reset held with every master requesting
    #12;
    checkOutput("rst_gnt",   64'(gnt),       64'(0));
    checkOutput("rst_cyc",   64'(bus.CYC_I), 64'(0));
    checkOutput("rst_adr",   64'(bus.ADR_I), 64'(0));
    checkOutput("rst_ack",   64'(bus.m_ack), 64'(0));
    checkOutput("rst_busy",  64'(busy),      64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("first_gnt",  64'(gnt),       64'(4'b0001));
    checkOutput("first_busy", 64'(busy),      64'(1));
    checkOutput("first_cyc",  64'(bus.CYC_I), 64'(1));
    checkOutput("first_adr",  64'(bus.ADR_I), 64'(32'h0000_1000));

    // Idle bus: stray bridge responses are not forwarded, outputs stay zero
    do_reset();
    adr_r[2] = 32'hFFFF_0000;
    spur_ack = 1'b1; spur_rty = 1'b1; spur_err = 1'b1;
    #1;
    checkOutput("stray_ack", 64'(bus.m_ack), 64'(0));
    checkOutput("stray_rty", 64'(bus.m_rty), 64'(0));
    checkOutput("stray_err", 64'(bus.m_err), 64'(0));
    checkOutput("idle_adr",  64'(bus.ADR_I), 64'(0));
    spur_ack = 1'b0; spur_rty = 1'b0; spur_err = 1'b0;

    // Single master write with a slow bridge, then GAP and IDLE
    do_reset();
    resp_delay = 3;
    push_txn(2, 32'h1000_0040, 32'hDEAD_BEEF, 1'b1, 1, 1'b0);
    applyStimulus(2, 32'h1000_0040, 32'hDEAD_BEEF, 1'b1, 1, 1'b0);
    tick();
    checkOutput("gap_busy", 64'(busy),      64'(0));
    checkOutput("gap_gnt",  64'(gnt),       64'(0));
    checkOutput("gap_cyc",  64'(bus.CYC_I), 64'(0));
    tick();
    checkOutput("idle_busy", 64'(busy), 64'(0));

    // Round robin with everyone requesting; master 0 comes back for a second turn
    do_reset();
    resp_delay = 1;
    push_txn(0, 32'h3000_0000, 32'h0000_0A00, 1'b1, 1, 1'b0);
    push_txn(1, 32'h3000_0100, 32'h0000_0A01, 1'b1, 1, 1'b0);
    push_txn(2, 32'h3000_0200, 32'h0000_0A02, 1'b1, 1, 1'b0);
    push_txn(3, 32'h3000_0300, 32'h0000_0A03, 1'b1, 1, 1'b0);
    push_txn(0, 32'h3000_0400, 32'h0000_0B00, 1'b1, 1, 1'b0);
    gap_check_en = 1'b1;
    fork
      begin
        applyStimulus(0, 32'h3000_0000, 32'h0000_0A00, 1'b1, 1, 1'b0);
        @(negedge clk);
        applyStimulus(0, 32'h3000_0400, 32'h0000_0B00, 1'b1, 1, 1'b0);
      end
      applyStimulus(1, 32'h3000_0100, 32'h0000_0A01, 1'b1, 1, 1'b0);
      applyStimulus(2, 32'h3000_0200, 32'h0000_0A02, 1'b1, 1, 1'b0);
      applyStimulus(3, 32'h3000_0300, 32'h0000_0A03, 1'b1, 1, 1'b0);
    join
    repeat (3) @(negedge clk);
    gap_check_en = 1'b0;

    // Burst hold: master 1 reads 4 beats while master 3 waits
    do_reset();
    resp_delay = 1;
    push_txn(1, 32'h2000_0000, 32'h0, 1'b0, 4, 1'b0);
    push_txn(3, 32'h2000_1000, 32'h1234_5678, 1'b1, 1, 1'b0);
    fork
      applyStimulus(1, 32'h2000_0000, 32'h0, 1'b0, 4, 1'b0);
      applyStimulus(3, 32'h2000_1000, 32'h1234_5678, 1'b1, 1, 1'b0);
    join

    // Retry fairness: master 0 is retried and loses the re-request to master 1
    do_reset();
    resp_delay = 0;
    push_txn(0, 32'h4000_0000, 32'h0000_00C0, 1'b1, 1, 1'b1);
    push_txn(1, 32'h4000_0100, 32'h0000_00C1, 1'b1, 1, 1'b0);
    push_txn(0, 32'h4000_0000, 32'h0000_00C0, 1'b1, 1, 1'b0);
    fork
      begin
        applyStimulus(0, 32'h4000_0000, 32'h0000_00C0, 1'b1, 1, 1'b1);
        @(negedge clk);
        applyStimulus(0, 32'h4000_0000, 32'h0000_00C0, 1'b1, 1, 1'b0);
      end
      applyStimulus(1, 32'h4000_0100, 32'h0000_00C1, 1'b1, 1, 1'b0);
    join

    // Hung slave: master 0 strobes and the bridge never answers
    do_reset();
    bridge_en = 1'b0;
    adr_r[0]  = 32'h5000_0000;
    sel_r[0]  = 4'hF;
    cyc_r[0]  = 1'b1;
    stb_r[0]  = 1'b1;
    begin
      int tries;
      tries = 0;
      tick();
      while (gnt != 4'b0001 && tries < 10) begin
        tick();
        tries++;
      end
      checkOutput("hung_granted", 64'(gnt), 64'(4'b0001));
    end
`ifdef PCI_BRIDGE_WB_ARB_WATCHDOG_EN
    begin
      int fire_at;
      fire_at = -1;
      for (int k = 1; k <= 1100 && fire_at < 0; k++) begin
        tick();
        if (bus.m_err[0]) begin
          fire_at = k;
          checkOutput("wd_err_vec", 64'(bus.m_err), 64'(4'b0001));
          checkOutput("wd_cyc_drop", 64'(bus.CYC_I), 64'(0));
        end
      end
      checkOutput("wd_fire_cycle", 64'(fire_at), 64'(1023));
      tick();
      checkOutput("wd_err_once", 64'(bus.m_err), 64'(0));
      checkOutput("wd_cyc_held", 64'(bus.CYC_I), 64'(0));
      checkOutput("wd_still_owned", 64'(busy), 64'(1));
      @(negedge clk);
      cyc_r[0] = 1'b0;
      stb_r[0] = 1'b0;
      tick();
      checkOutput("wd_released", 64'(busy), 64'(0));
    end
`else
    for (int k = 0; k < 2000; k++) tick();
    checkOutput("hung_cyc", 64'(bus.CYC_I), 64'(1));
    checkOutput("hung_gnt", 64'(gnt),       64'(4'b0001));
    checkOutput("hung_err", 64'(bus.m_err), 64'(0));
    // Asynchronous reset in the middle of the cycle drops CYC_I at once
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_cyc", 64'(bus.CYC_I), 64'(0));
    checkOutput("midrst_gnt", 64'(gnt),       64'(0));
    checkOutput("midrst_ack", 64'(bus.m_ack), 64'(0));
    cyc_r[0] = 1'b0;
    stb_r[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif
    bridge_en = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
